ifft8_seq: RTL and testbench
============================

IFFT8_SEQ -- requirements
Module: ifft8_seq

Interface
REQ-001 Parameter DW, default 16: sample component width, two's complement.
REQ-002 Parameter FRAC, default 8: fractional bits; format is Q(DW-FRAC).FRAC, so 1.0 = 0x0100.
REQ-003 Clock and reset: one clock, clk; reset rst is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 write  input  1  load request; samples xr/xi captured when accepted.
REQ-007 start  input  1  compute request.
REQ-008 xr  input  8*DW  real parts of frequency bins X0..X7, with X0 in bits [DW-1:0].
REQ-009 xi  input  8*DW  imaginary parts of X0..X7, packed as for xr.
REQ-010 yr  output  8*DW  real parts of time samples y0..y7, registered.
REQ-011 yi  output  8*DW  imaginary parts of y0..y7, registered.
REQ-012 ready  output  1  yr/yi valid for the current frame.
REQ-013 busy  output  1  high while in RUN.
REQ-014 state  output  2  FSM state: IDLE=00, LOADED=01, RUN=10, DONE=11.

Function
REQ-015 Transform: yn = sum over k of Xk*exp(+j2*pi*nk/8), radix-2 decimation-in-time, using conjugate twiddles W0=(0x0100,0), W1=(0x00B5,0x00B5), W2=(0,0x0100), W3=(0xFF4B,0x00B5).
REQ-016 Datapath: one butterfly unit, time-shared; 3 stages x 4 butterflies = 12 compute cycles; 8-entry complex working register file.
REQ-017 IDLE: write=1 captures xr/xi into working registers in bit-reversed order (0,4,2,6,1,5,3,7) -> LOADED; start is ignored.
REQ-018 LOADED: write=1 recaptures xr/xi and stays LOADED; else start=1 -> RUN with butterfly counter 0; write has priority when both are high.
REQ-019 RUN: one butterfly per cycle, counter 0..11, results written back in place; write and start are ignored; after counter 11 -> DONE.
REQ-020 Latency: the start edge is cycle 0; yr/yi are updated and ready rises at the edge 13 cycles later.
REQ-021 DONE: ready=1 and yr/yi held; start=1 ignored; write=1 captures a new frame -> LOADED and clears ready; yr/yi are held until overwritten.
REQ-022 Butterfly arithmetic: each product is 2*DW signed; bits [FRAC+DW-1:FRAC] are kept (truncation toward -inf); sums and differences wrap modulo 2^DW with no saturation.
REQ-023 busy=1 exactly when state=RUN.

Reset
REQ-024 rst low: state=IDLE, ready=0, busy=0, yr=0, yi=0, working registers=0, counter=0, effective immediately.
REQ-025 Reset during RUN aborts the frame; no partial result ever reaches yr/yi.
REQ-026 The first frame after reset release requires a new write.

Configuration
REQ-027 Macro IFFT8_SCALE_EN defined: each butterfly output is arithmetic-shifted right by 1 after the add/subtract, giving a total scale of 1/8 (true inverse DFT).
REQ-028 Macro IFFT8_SCALE_EN undefined: no shift; outputs equal 8 x the inverse DFT, with wrap per REQ-022.

Structure
REQ-029 Package ifft8_pkg holds: DW/FRAC defaults, the state encoding constants, the four twiddle constants, and the bit-reverse index table.
REQ-030 Sub-module ifft_bfly: combinational complex butterfly (a +/- b*w), containing the product truncation and the IFFT8_SCALE_EN shift.
REQ-031 The FSM, counter, twiddle/address sequencing and register file reside in ifft8_seq.

Verification
REQ-032 SCALE_EN, X0=(0x0100,0), other bins 0: write, start -> after 13 cycles ready=1 and every yn=(0x0020,0x0000).
REQ-033 SCALE_EN, all Xk=(0x0100,0): y0=(0x0100,0), y1..y7=(0,0) within 1 LSB.
REQ-034 SCALE_EN, X1=(0x0800,0), others 0: y1~(0x00B5,0x00B5), y2=(0,0x0100), y4=(0xFF00,0), within 2 LSB.
REQ-035 Handshake: start in IDLE -> no state change. Write+start together in LOADED -> stays LOADED with new data. Write/start during RUN -> ignored; the result matches the original frame.
REQ-036 Reset asserted at RUN counter 5 -> immediately state=00, ready=0, yr=yi=0. After release: write, start -> correct result with 13-cycle latency.
REQ-037 Scale disabled: the REQ-032 stimulus yields every yn=(0x0100,0).

Source files
------------

// File: rtl/ifft8_pkg.sv
// Shared constants for the 8-point sequential IFFT.
// Holds widths, FSM encoding, conjugate twiddles and butterfly schedule.
package ifft8_pkg;

  localparam int DW_DEF   = 16;
  localparam int FRAC_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOADED = 2'b01,
    ST_RUN    = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'd12;

  localparam int TW_RE [4] = '{256, 181, 0, -181};
  localparam int TW_IM [4] = '{0, 181, 256, 181};

  localparam int BITREV [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  typedef struct packed {
    logic [2:0] top;
    logic [2:0] bot;
    logic [1:0] tw;
  } bf_t;

  // Counter bits [3:2] select the stage, [1:0] the butterfly in it.
  function automatic bf_t bf_sched(input logic [3:0] c);
    bf_t r;
    logic [1:0] b;
    b = c[1:0];
    r = '0;
    unique case (c[3:2])
      2'd0: begin
        r.top = {b, 1'b0};
        r.bot = {b, 1'b1};
        r.tw  = 2'd0;
      end
      2'd1: begin
        r.top = {b[1], 1'b0, b[0]};
        r.bot = {b[1], 1'b1, b[0]};
        r.tw  = {b[0], 1'b0};
      end
      default: begin
        r.top = {1'b0, b};
        r.bot = {1'b1, b};
        r.tw  = b;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 complex butterfly: a + b*w and a - b*w.
// Optional halving of each output under IFFT8_SCALE_EN.
module ifft_bfly
  import ifft8_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [DW-1:0] i_a_re,
  input  logic signed [DW-1:0] i_a_im,
  input  logic signed [DW-1:0] i_b_re,
  input  logic signed [DW-1:0] i_b_im,
  input  logic signed [DW-1:0] i_w_re,
  input  logic signed [DW-1:0] i_w_im,
  output logic signed [DW-1:0] o_p_re,
  output logic signed [DW-1:0] o_p_im,
  output logic signed [DW-1:0] o_m_re,
  output logic signed [DW-1:0] o_m_im
);

  logic signed [2*DW-1:0] w_rr, w_ii, w_ri, w_ir;
  logic signed [DW-1:0]   w_t_re, w_t_im;
  logic signed [DW:0]     w_p_re, w_p_im;
  logic signed [DW:0]     w_m_re, w_m_im;

  assign w_rr = i_b_re * i_w_re;
  assign w_ii = i_b_im * i_w_im;
  assign w_ri = i_b_re * i_w_im;
  assign w_ir = i_b_im * i_w_re;

  // Each product is floored back to DW bits before combining.
  assign w_t_re = DW'(w_rr >>> FRAC) - DW'(w_ii >>> FRAC);
  assign w_t_im = DW'(w_ri >>> FRAC) + DW'(w_ir >>> FRAC);

  assign w_p_re = {i_a_re[DW-1], i_a_re} + {w_t_re[DW-1], w_t_re};
  assign w_p_im = {i_a_im[DW-1], i_a_im} + {w_t_im[DW-1], w_t_im};
  assign w_m_re = {i_a_re[DW-1], i_a_re} - {w_t_re[DW-1], w_t_re};
  assign w_m_im = {i_a_im[DW-1], i_a_im} - {w_t_im[DW-1], w_t_im};

`ifdef IFFT8_SCALE_EN
  assign o_p_re = DW'(w_p_re >>> 1);
  assign o_p_im = DW'(w_p_im >>> 1);
  assign o_m_re = DW'(w_m_re >>> 1);
  assign o_m_im = DW'(w_m_im >>> 1);
`else
  assign o_p_re = DW'(w_p_re);
  assign o_p_im = DW'(w_p_im);
  assign o_m_re = DW'(w_m_re);
  assign o_m_im = DW'(w_m_im);
`endif

endmodule

// File: rtl/ifft8_seq.sv
// 8-point sequential IFFT with one time-shared butterfly.
// Define IFFT8_SCALE_EN for a 1/8-scaled (true inverse DFT) result.
module ifft8_seq
  import ifft8_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write,
  input  logic            start,
  input  logic [8*DW-1:0] xr,
  input  logic [8*DW-1:0] xi,
  output logic [8*DW-1:0] yr,
  output logic [8*DW-1:0] yi,
  output logic            ready,
  output logic            busy,
  output logic [1:0]      state
);

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic                 r_ready;
  logic [8*DW-1:0]      r_yr, r_yi;
  logic signed [DW-1:0] r_re [8];
  logic signed [DW-1:0] r_im [8];

  bf_t                  w_sch;
  logic                 w_load, w_bf;
  logic signed [DW-1:0] w_wr, w_wi;
  logic signed [DW-1:0] w_pr, w_pi, w_mr, w_mi;

  assign w_sch  = bf_sched(r_cnt);
  assign w_load = write && (r_state != ST_RUN);
  assign w_bf   = (r_state == ST_RUN) && (r_cnt != LAST_CNT);
  assign w_wr   = DW'(TW_RE[w_sch.tw]);
  assign w_wi   = DW'(TW_IM[w_sch.tw]);

  ifft_bfly #(.DW(DW), .FRAC(FRAC)) u_bfly (
    .i_a_re (r_re[w_sch.top]),
    .i_a_im (r_im[w_sch.top]),
    .i_b_re (r_re[w_sch.bot]),
    .i_b_im (r_im[w_sch.bot]),
    .i_w_re (w_wr),
    .i_w_im (w_wi),
    .o_p_re (w_pr),
    .o_p_im (w_pi),
    .o_m_re (w_mr),
    .o_m_im (w_mi)
  );

  // Working registers: bit-reversed load, then in-place butterflies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else if (w_load) begin
      for (int i = 0; i < 8; i++) begin
        r_re[i] <= xr[BITREV[i]*DW +: DW];
        r_im[i] <= xi[BITREV[i]*DW +: DW];
      end
    end else if (w_bf) begin
      r_re[w_sch.top] <= w_pr;
      r_im[w_sch.top] <= w_pi;
      r_re[w_sch.bot] <= w_mr;
      r_im[w_sch.bot] <= w_mi;
    end
  end

  // Control FSM, butterfly counter and registered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_yr    <= '0;
      r_yi    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (write) r_state <= ST_LOADED;
        end
        ST_LOADED: begin
          if (!write && start) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (r_cnt == LAST_CNT) begin
            for (int i = 0; i < 8; i++) begin
              r_yr[i*DW +: DW] <= r_re[i];
              r_yi[i*DW +: DW] <= r_im[i];
            end
            r_ready <= 1'b1;
            r_state <= ST_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          if (write) begin
            r_state <= ST_LOADED;
            r_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  assign yr    = r_yr;
  assign yi    = r_yi;
  assign ready = r_ready;
  assign busy  = (r_state == ST_RUN);
  assign state = r_state;

endmodule

// File: tb/tb_ifft8_seq.sv
// Randomized self-checking bench for ifft8_seq.
// Reference: textbook DIT IFFT on integer arrays with Q8 truncation.
module tb_ifft8_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         write = 1'b0;
  logic         start = 1'b0;
  logic [127:0] xr = '0;
  logic [127:0] xi = '0;
  logic [127:0] yr, yi;
  logic         ready, busy;
  logic [1:0]   state;

  int n_chk  = 0;
  int n_fail = 0;
  logic [127:0] lyr, lyi;

  ifft8_seq #(.DW(16), .FRAC(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .write (write),
    .start (start),
    .xr    (xr),
    .xi    (xi),
    .yr    (yr),
    .yi    (yi),
    .ready (ready),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int w16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return s16(t);
  endfunction

  // Conjugate-twiddle radix-2 DIT inverse FFT, integer arithmetic.
  task automatic model(input logic [127:0] ar, input logic [127:0] ai,
                       output logic [127:0] er, output logic [127:0] ei);
    int re [8];
    int im [8];
    int wr [4] = '{256, 181, 0, -181};
    int wi [4] = '{0, 181, 256, 181};
    int r, k, a, b, tr, ti, sr, si, dr, di;
    for (int i = 0; i < 8; i++) begin
      r = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
      re[i] = s16(ar[r*16 +: 16]);
      im[i] = s16(ai[r*16 +: 16]);
    end
    for (int h = 1; h < 8; h = h * 2) begin
      for (int g = 0; g < 8; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          k = j * 4 / h;
          a = g + j;
          b = a + h;
          tr = w16(w16((re[b] * wr[k]) >>> 8) - w16((im[b] * wi[k]) >>> 8));
          ti = w16(w16((re[b] * wi[k]) >>> 8) + w16((im[b] * wr[k]) >>> 8));
          sr = re[a] + tr;
          si = im[a] + ti;
          dr = re[a] - tr;
          di = im[a] - ti;
`ifdef IFFT8_SCALE_EN
          sr = sr >>> 1;
          si = si >>> 1;
          dr = dr >>> 1;
          di = di >>> 1;
`endif
          re[a] = w16(sr);
          im[a] = w16(si);
          re[b] = w16(dr);
          im[b] = w16(di);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      er[i*16 +: 16] = re[i][15:0];
      ei[i*16 +: 16] = im[i][15:0];
    end
  endtask

  // Optional load, start, wait for ready with a bound, compare result.
  task automatic run_frame(input string tag,
                           input logic [127:0] ar,
                           input logic [127:0] ai,
                           input bit do_write,
                           input bit disturb);
    int lat;
    logic [127:0] er, ei;
    model(ar, ai, er, ei);
    if (do_write) begin
      @(negedge clk);
      write = 1'b1;
      xr = ar;
      xi = ai;
    end
    @(negedge clk);
    write = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = n;
        break;
      end
      if (disturb && n <= 4) begin
        write = 1'b1;
        start = 1'b1;
        xr = {$urandom, $urandom, $urandom, $urandom};
        xi = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        write = 1'b0;
        start = 1'b0;
      end
    end
    write = 1'b0;
    start = 1'b0;
    chk({tag, "_lat"}, 128'(lat), 128'(13));
    chk({tag, "_yr"}, yr, er);
    chk({tag, "_yi"}, yi, ei);
    lyr = er;
    lyi = ei;
  endtask

  logic [127:0] ar, ai, e32;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 128'(state), 128'(0));
    chk("rst_ready", 128'(ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_yr", yr, '0);
    chk("rst_yi", yi, '0);
    @(negedge clk);
    rst = 1'b1;

    // Start in IDLE ignored
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_start", 128'(state), 128'(0));

    // Single DC bin
    ar = '0;
    ai = '0;
    ar[15:0] = 16'h0100;
    run_frame("x0", ar, ai, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
`ifdef IFFT8_SCALE_EN
      e32[i*16 +: 16] = 16'h0020;
`else
      e32[i*16 +: 16] = 16'h0100;
`endif
    end
    chk("x0_const_yr", yr, e32);
    chk("x0_const_yi", yi, '0);
    chk("done_state", 128'(state), 128'(3));

    // All bins at 1.0
    for (int i = 0; i < 8; i++) ar[i*16 +: 16] = 16'h0100;
    run_frame("flat", ar, '0, 1'b1, 1'b0);

    // Start in DONE ignored, then write clears ready and holds outputs
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start", 128'(state), 128'(3));
    chk("done_ready", 128'(ready), 128'(1));
    ar = '0;
    ar[31:16] = 16'h0800;
    @(negedge clk);
    write = 1'b1;
    xr = ar;
    xi = '0;
    @(negedge clk);
    write = 1'b0;
    chk("reload_state", 128'(state), 128'(1));
    chk("reload_ready", 128'(ready), 128'(0));
    chk("reload_hold", yr, lyr);
    run_frame("x1", ar, '0, 1'b0, 1'b0);

    // Write beats start in LOADED
    ar = {$urandom, $urandom, $urandom, $urandom};
    ai = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    write = 1'b1;
    xr = ~ar;
    xi = ~ai;
    @(negedge clk);
    start = 1'b1;
    xr = ar;
    xi = ai;
    @(negedge clk);
    write = 1'b0;
    start = 1'b0;
    chk("ws_state", 128'(state), 128'(1));
    run_frame("ws", ar, ai, 1'b0, 1'b0);

    // Write/start during RUN ignored
    ar = {$urandom, $urandom, $urandom, $urandom};
    ai = {$urandom, $urandom, $urandom, $urandom};
    run_frame("dist", ar, ai, 1'b1, 1'b1);

    // Random full-range frames
    for (int f = 0; f < 6; f++) begin
      ar = {$urandom, $urandom, $urandom, $urandom};
      ai = {$urandom, $urandom, $urandom, $urandom};
      run_frame("rnd", ar, ai, 1'b1, 1'b0);
    end

    // Reset at butterfly counter 5
    ar = {$urandom, $urandom, $urandom, $urandom};
    ai = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    write = 1'b1;
    xr = ar;
    xi = ai;
    @(negedge clk);
    write = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_state", 128'(state), 128'(0));
    chk("abort_ready", 128'(ready), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_yr", yr, '0);
    chk("abort_yi", yi, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_start", 128'(state), 128'(0));
    run_frame("post_rst", ar, ai, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
